// File: rtl/mmio_uart_responder.sv
// mmio_uart_responder
//   MMIO slave for the 0x8xxx_xxxx region. It returns registered load data
//   one cycle after the request, the same latency as dmem. It also holds a
//   one-byte TX slot, keeps an RX byte FIFO, and maintains the cycle and
//   retired-instruction counters.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req_valid/we    CPU access strobe and store flag (EX stage)
//   req_addr/wdata  byte address and store data (TX uses wdata[7:0])
//   inst_retire     one pulse per retired instruction
//   rdata/valid     registered load response, valid for one cycle
//   tx_data/valid   outgoing byte, handshaken with tx_ready
//   rx_data/valid   incoming byte, accepted when rx_ready is high
//
// Register offsets (req_addr[7:0])
//   0x00 ctrl  (load)   bit0 = TX slot free, bit1 = RX FIFO non-empty
//   0x04 rx    (load)   FIFO head, popping it; reads 0 when the FIFO is empty
//   0x08 tx    (store)  writes the TX byte
//   0x10 cycle (load)
//   0x14 instret (load)
//   0x18 clear (store)  zeroes both counters
module mmio_uart_responder #(
  parameter int RX_FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        inst_retire,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(RX_FIFO_DEPTH);

  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_RX      = 8'h04;
  localparam logic [7:0] OFF_TX      = 8'h08;
  localparam logic [7:0] OFF_CYCLE   = 8'h10;
  localparam logic [7:0] OFF_INSTRET = 8'h14;
  localparam logic [7:0] OFF_CLEAR   = 8'h18;

  // State
  logic [7:0]    fifo_mem [RX_FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [AW:0]   count_reg;
  logic [7:0]    tx_data_reg;
  logic          tx_valid_reg;
  logic [31:0]   cycle_reg, instret_reg;
  logic [31:0]   rdata_reg;
  logic          rdata_valid_reg;

  // Decode
  logic       hit, load_hit, store_hit;
  logic [7:0] offset;
  logic       fifo_nonempty, push, pop, tx_accept, clear;
  logic [31:0] read_value;

  // Only the top nibble and the low byte of the address are decoded.
  logic unused_bits;
  assign unused_bits = ^{req_addr[27:8], req_wdata[31:8]};

  assign hit       = req_valid && (req_addr[31:28] == 4'h8);
  assign load_hit  = hit && !req_we;
  assign store_hit = hit && req_we;
  assign offset    = req_addr[7:0];

  assign fifo_nonempty = (count_reg != '0);
  assign rx_ready      = (count_reg != FULL_COUNT);
  assign push          = rx_valid && rx_ready;
  assign pop           = load_hit && (offset == OFF_RX) && fifo_nonempty;

  // The slot can be refilled on the same edge the transmitter takes the old
  // byte, so back-to-back writes keep tx_valid high without a bubble.
  assign tx_accept = store_hit && (offset == OFF_TX) && (!tx_valid_reg || tx_ready);
  assign clear     = store_hit && (offset == OFF_CLEAR);

  // Read mux sees pre-edge state, so counters read before their increment
  // and ctrl reflects state before this edge's updates.
  always_comb begin
    read_value = '0;
    case (offset)
      OFF_CTRL:    read_value = {30'b0, fifo_nonempty, !tx_valid_reg};
      OFF_RX:      read_value = fifo_nonempty ? {24'b0, fifo_mem[rd_ptr_reg]} : 32'h0;
      OFF_CYCLE:   read_value = cycle_reg;
      OFF_INSTRET: read_value = instret_reg;
      default:     read_value = '0;
    endcase
  end

  // Load response; rdata holds its last value between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg       <= '0;
      rdata_valid_reg <= 1'b0;
    end else begin
      rdata_valid_reg <= load_hit;
      if (load_hit) begin
        rdata_reg <= read_value;
      end
    end
  end

  // RX FIFO storage (no reset: contents are meaningless once pointers clear)
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // TX holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_reg  <= '0;
      tx_valid_reg <= 1'b0;
    end else if (tx_accept) begin
      tx_data_reg  <= req_wdata[7:0];
      tx_valid_reg <= 1'b1;
    end else if (tx_valid_reg && tx_ready) begin
      tx_valid_reg <= 1'b0;
    end
  end

  // Counters; a clear store wins over the same-edge increment.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cycle_reg   <= '0;
      instret_reg <= '0;
    end else begin
      cycle_reg   <= cycle_reg + 32'd1;
      instret_reg <= instret_reg + {31'b0, inst_retire};
    end
  end

  assign rdata       = rdata_reg;
  assign rdata_valid = rdata_valid_reg;
  assign tx_data     = tx_data_reg;
  assign tx_valid    = tx_valid_reg;

endmodule

// File: tb/tb_mmio_uart_responder.sv
// Self-checking bench for mmio_uart_responder. Load responses go through a
// scoreboard queue; a monitor pops and compares them whenever rdata_valid is seen.
module tb_mmio_uart_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        inst_retire;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  mmio_uart_responder #(.RX_FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .inst_retire(inst_retire),
    .rdata(rdata), .rdata_valid(rdata_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q [$];
  exp_t mon_e;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor: outputs sampled on the falling edge.
  always @(negedge clk) begin
    if (rdata_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rdata_unexpected: got valid with 0x%08h, required no response", rdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (rdata !== mon_e.data) begin
          n_fail++;
          $display("FAIL rdata @0x%08h: got 0x%08h, required 0x%08h", mon_e.addr, rdata, mon_e.data);
        end else begin
          $display("load  0x%08h -> 0x%08h", mon_e.addr, rdata);
        end
      end
    end
  end

  // One-cycle load expecting a response on the following cycle.
  task automatic load(input logic [31:0] addr, input logic [31:0] exp);
    exp_t e;
    e.addr = addr;
    e.data = exp;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = addr;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("resp_missing", exp_q.size(), 0);
  endtask

  // One-cycle access that must not produce a response.
  task automatic access_noresp(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    check("no_resp", rdata_valid, 1'b0);
    $display("%s 0x%08h data 0x%08h (no response)", we ? "store" : "load ", addr, wdata);
    #1;
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    $display("rx    push 0x%02h", b);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 32'h8000_0004, 32'h0,    1'b1, 32'h0};
    vecs[1]  = '{1'b0, 32'h8000_0014, 32'h0,    1'b1, 32'h0};
    vecs[2]  = '{1'b0, 32'h8000_0020, 32'h0,    1'b1, 32'h0};
    vecs[3]  = '{1'b0, 32'h8000_00FC, 32'h0,    1'b1, 32'h0};
    vecs[4]  = '{1'b0, 32'h8123_4500, 32'h0,    1'b1, 32'h1};
    vecs[5]  = '{1'b0, 32'h9000_0000, 32'h0,    1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_0010, 32'h0,    1'b0, 32'h0};
    vecs[7]  = '{1'b1, 32'h8000_0000, 32'hFF,   1'b0, 32'h0};
    vecs[8]  = '{1'b1, 32'h8000_0010, 32'h1234, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 32'h7000_0008, 32'h55,   1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'h8000_000C, 32'h0,    1'b1, 32'h0};
    vecs[11] = '{1'b0, 32'h8000_0018, 32'h0,    1'b1, 32'h0};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    inst_retire = 1'b0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_rdata", rdata, 32'h0);
    check("rst_rdata_valid", rdata_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_rx_ready", rx_ready, 1'b1);

    // Five idle cycles, then the cycle counter reads 5.
    repeat (5) @(negedge clk);
    load(32'h8000_0010, 32'd5);
    load(32'h8000_0000, 32'h1);

    // Register map table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].resp) load(vecs[i].addr, vecs[i].exp);
      else access_noresp(vecs[i].we, vecs[i].addr, vecs[i].wdata);
    end
    check("tx_idle_after_table", tx_valid, 1'b0);

    // TX slot held while tx_ready is low; a second write is dropped.
    access_noresp(1'b1, 32'h8000_0008, 32'h41);
    check("tx_valid_set", tx_valid, 1'b1);
    check("tx_data_41", tx_data, 8'h41);
    access_noresp(1'b1, 32'h8000_0008, 32'h42);
    check("tx_drop_valid", tx_valid, 1'b1);
    check("tx_drop_data", tx_data, 8'h41);
    load(32'h8000_0000, 32'h0);
    check("tx_hold_data", tx_data, 8'h41);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check("tx_valid_fall", tx_valid, 1'b0);
    $display("tx    handshake 0x41");

    // Back-to-back write on the handshake cycle: no bubble.
    access_noresp(1'b1, 32'h8000_0008, 32'h61);
    check("tx_data_61", tx_data, 8'h61);
    tx_ready = 1'b1;
    access_noresp(1'b1, 32'h8000_0008, 32'h62);
    check("tx_b2b_valid", tx_valid, 1'b1);
    check("tx_b2b_data", tx_data, 8'h62);
    @(negedge clk);
    tx_ready = 1'b0;
    check("tx_b2b_fall", tx_valid, 1'b0);

    // RX FIFO ordering and empty read
    push_rx(8'h11); push_rx(8'h22); push_rx(8'h33);
    load(32'h8000_0000, 32'h3);
    load(32'h8000_0004, 32'h11);
    load(32'h8000_0004, 32'h22);
    load(32'h8000_0004, 32'h33);
    load(32'h8000_0004, 32'h0);
    load(32'h8000_0000, 32'h1);

    // Fill, hold a 9th byte, pop once, and confirm wrap order.
    for (int i = 0; i < 8; i++) push_rx(8'hA0 + 8'(i));
    check("full_rx_ready", rx_ready, 1'b0);
    rx_valid = 1'b1;
    rx_data  = 8'hA8;
    @(negedge clk);
    check("full_hold_rx_ready", rx_ready, 1'b0);
    load(32'h8000_0004, 32'hA0);
    check("after_pop_rx_ready", rx_ready, 1'b1);
    @(negedge clk);
    rx_valid = 1'b0;
    check("refull_rx_ready", rx_ready, 1'b0);
    for (int i = 1; i <= 8; i++) load(32'h8000_0004, 32'hA0 + 32'(i));
    load(32'h8000_0004, 32'h0);
    load(32'h8000_0000, 32'h1);

    // Counters: 4 retires, then clear concurrent with a retire.
    repeat (4) begin
      inst_retire = 1'b1;
      @(negedge clk);
      inst_retire = 1'b0;
    end
    load(32'h8000_0014, 32'd4);
    inst_retire = 1'b1;
    access_noresp(1'b1, 32'h8000_0018, 32'h0);
    inst_retire = 1'b0;
    load(32'h8000_0014, 32'd0);
    load(32'h8000_0010, 32'd1);

    // Reset mid-operation
    push_rx(8'h55); push_rx(8'h66); push_rx(8'h77);
    access_noresp(1'b1, 32'h8000_0008, 32'h77);
    check("pre_rst_tx_valid", tx_valid, 1'b1);
    rst       = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h8000_0000;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_drops_resp", rdata_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_tx_valid", tx_valid, 1'b0);
    check("mid_rst_tx_data", tx_data, 8'h0);
    check("mid_rst_rx_ready", rx_ready, 1'b1);
    $display("rst   mid-operation");
    load(32'h8000_0000, 32'h1);
    load(32'h8000_0004, 32'h0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_uart_responder.md
# mmio_uart_responder

Memory-mapped I/O responder between the CPU datapath and the on-chip UART. Decodes CPU loads/stores in the 0x8xxx_xxxx region and returns registered read data with the same one-cycle latency as dmem. Buffers received bytes in an RX FIFO, holds one outgoing TX byte with a valid/ready handshake, and maintains the cycle and retired-instruction counters.

## Interface
- RX_FIFO_DEPTH, 8, RX FIFO entries; must be a power of two, at least 2
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  CPU memory access presented this cycle (EX stage)
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data; only [7:0] used for TX
- inst_retire  in  1  one pulse per retired instruction
- rdata  out  32  load response data
- rdata_valid  out  1  rdata valid for one cycle
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  FIFO can accept a byte

## Operation
- Hit: req_valid && req_addr[31:28] == 4'h8. Offset is req_addr[7:0]. Non-hits are ignored entirely.
- Register map (loads):
  - 0x00 ctrl: bit0 = !tx_valid (TX slot free); bit1 = FIFO non-empty; other bits 0.
  - 0x04 rx data: {24'b0, FIFO head}; pops one entry. When empty, returns 0 and does not pop.
  - 0x10 cycle counter.
  - 0x14 instret counter.
  - Any other offset returns 0.
- Register map (stores):
  - 0x08 tx data: accepted if tx_valid == 0, or if tx_valid && tx_ready this cycle. Otherwise dropped silently; software polls ctrl bit0.
  - 0x18 any value: clears both counters.
  - Any other offset has no effect.
- Store hits never assert rdata_valid.
- TX holding register:
  - An accepted write sets tx_data <= req_wdata[7:0] and tx_valid <= 1.
  - On tx_valid && tx_ready with no accepted write, tx_valid <= 0.
  - tx_data holds while tx_valid = 1.
- RX FIFO:
  - Circular buffer with read/write pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
  - rx_ready = (count != DEPTH), combinational from registered count.
  - Push on rx_valid && rx_ready; pop on a 0x04 load hit when count != 0.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Full: rx_ready = 0 even if a pop occurs that cycle; the receiver holds its byte.
  - Bytes are delivered in arrival order.
- Counters (32-bit, wrap 0xFFFF_FFFF -> 0):
  - cycle increments every cycle.
  - instret increments on inst_retire.
  - A clear store overrides the same-cycle increment, so both counters read 0 on the next cycle.

## Timing
- Load hit sampled at edge N; rdata/rdata_valid are valid during cycle N+1 and are registered.
- rdata_valid = 0 in any cycle without a load hit at the previous edge. rdata holds its last value.
- Counter reads return the value before the sampling edge's increment.
- A ctrl read reflects state before the same edge's updates.
- A FIFO pop at edge N is visible in ctrl bit1 from cycle N+1.
- A TX write at edge N asserts tx_valid in cycle N+1.
- A back-to-back write on the handshake cycle keeps tx_valid continuously high, with no bubble.
- Reset values:
  - rdata = 0, rdata_valid = 0, tx_data = 0, tx_valid = 0.
  - FIFO empty (rx_ready = 1 in the first cycle after reset).
  - cycle = 0, instret = 0.
- Reset mid-operation discards FIFO contents and any pending TX byte, and drops any in-flight response.

## Test plan
- Reset, then 5 idle cycles, then load 0x8000_0010 -> rdata_valid 1 cycle later with rdata = 5. Load 0x8000_0000 -> rdata = 0x1.
- Store 0x41 to 0x8000_0008 with tx_ready = 0 for 3 cycles -> tx_valid = 1 and tx_data = 0x41 held. Store 0x42 meanwhile -> dropped. Raise tx_ready -> tx_valid falls the next cycle.
- Push 0x11, 0x22, 0x33 via rx_valid -> ctrl = 0x3. Three 0x04 loads -> 0x11, 0x22, 0x33. Fourth load -> 0 and ctrl bit1 = 0.
- Push 8 bytes -> rx_ready = 0, and a 9th byte is held by the receiver. One pop -> rx_ready = 1 next cycle; the 9th byte is accepted and read last, confirming pointer wrap.
- Pulse inst_retire 4 times, then store to 0x8000_0018 concurrent with a retire -> instret and cycle read 0 on the next cycle.
- Assert rst with 3 bytes queued and tx_valid = 1 -> FIFO empty, tx_valid = 0, and ctrl = 0x1 after reset.
